// File: rtl/rpn_stack_unit.sv
// rpn_stack_unit: RPN operand stack with add/iterative signed multiply; define RPN_SUB_EN to enable SUB (op 5)
module rpn_stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op_code,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic                       top_valid,
  output logic [$clog2(DEPTH+1)-1:0] depth_count,
  output logic [DEPTH-1:0]           occupancy,
  output logic                       stack_oflw,
  output logic                       arith_oflw,
  output logic                       busy
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int MW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, MUL, COMMIT} state_t;
  state_t state;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] e0, e1, sum, res, abs0, abs1, mb;
  logic [2*WIDTH-1:0] ma, acc, prod;
  logic [MW-1:0] mcnt;
  logic neg, add_ov, res_ov, is_sub, mul_ov;
  logic go, two, push_ok, pop_ok, bin_ok, mul_ok, clr;
  assign e0 = stk[0];
  assign e1 = stk[1];
  assign sum = e0 + e1;
  assign add_ov = (e0[WIDTH-1] == e1[WIDTH-1]) && (sum[WIDTH-1] != e0[WIDTH-1]);
`ifdef RPN_SUB_EN
  logic [WIDTH-1:0] diff;
  logic sub_ov;
  assign diff = e1 - e0;
  assign sub_ov = (e0[WIDTH-1] != e1[WIDTH-1]) && (diff[WIDTH-1] != e1[WIDTH-1]);
  assign is_sub = op_code == 3'd5;
  assign res = is_sub ? diff : sum;
  assign res_ov = is_sub ? sub_ov : add_ov;
`else
  assign is_sub = 1'b0;
  assign res = sum;
  assign res_ov = add_ov;
`endif
  assign abs0 = e0[WIDTH-1] ? -e0 : e0;
  assign abs1 = e1[WIDTH-1] ? -e1 : e1;
  assign prod = neg ? -acc : acc;
  assign mul_ov = prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]};
  assign op_ready = state == IDLE;
  assign busy = ~op_ready;
  assign top = stk[0];
  assign top_valid = depth_count != '0;
  assign go = op_valid && op_ready;
  assign two = depth_count >= CW'(2);
  assign push_ok = go && op_code == 3'd1;
  assign pop_ok = go && op_code == 3'd2 && top_valid;
  assign bin_ok = go && (op_code == 3'd3 || is_sub) && two;
  assign mul_ok = go && op_code == 3'd4 && two;
  assign clr = go && op_code == 3'd6;
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy[i] = int'(depth_count) > i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      depth_count <= '0;
      stack_oflw <= 1'b0;
      arith_oflw <= 1'b0;
      state <= IDLE;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      mcnt <= '0;
      neg <= 1'b0;
    end else begin
      if (push_ok) begin
        for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
        stk[0] <= din;
        if (depth_count < CW'(DEPTH)) depth_count <= depth_count + CW'(1);
        else begin
          stack_oflw <= 1'b1;
          arith_oflw <= 1'b0;
        end
      end
      if (pop_ok || bin_ok || state == COMMIT) begin
        for (int i = 0; i < DEPTH-1; i++) stk[i] <= stk[i+1];
        stk[DEPTH-1] <= '0;
        depth_count <= depth_count - CW'(1);
        stack_oflw <= 1'b0;
      end
      if (pop_ok) arith_oflw <= 1'b0;
      if (bin_ok) begin
        stk[0] <= res;
        arith_oflw <= res_ov;
      end
      if (mul_ok) begin
        ma <= {{WIDTH{1'b0}}, abs0};
        mb <= abs1;
        acc <= '0;
        neg <= e0[WIDTH-1] ^ e1[WIDTH-1];
        mcnt <= MW'(WIDTH);
        state <= MUL;
      end
      if (state == MUL) begin
        acc <= acc + (mb[0] ? ma : '0);
        ma <= ma << 1;
        mb <= mb >> 1;
        mcnt <= mcnt - MW'(1);
        if (mcnt == MW'(1)) state <= COMMIT;
      end
      if (state == COMMIT) begin
        stk[0] <= prod[WIDTH-1:0];
        arith_oflw <= mul_ov;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rpn_stack_unit.sv
// tb_rpn_stack_unit: directed plus random ops checked against a queue-based RPN model
module tb_rpn_stack_unit;
  localparam int W = 8;
  localparam int D = 4;
`ifdef RPN_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic op_valid = 1'b0;
  logic [2:0] op_code = '0;
  logic [W-1:0] din = '0;
  logic op_ready, top_valid, stack_oflw, arith_oflw, busy;
  logic [W-1:0] top;
  logic [$clog2(D+1)-1:0] depth_count;
  logic [D-1:0] occupancy;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic m_so = 1'b0;
  logic m_ao = 1'b0;

  rpn_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .din(din), .top(top), .top_valid(top_valid),
    .depth_count(depth_count), .occupancy(occupancy), .stack_oflw(stack_oflw),
    .arith_oflw(arith_oflw), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = q.size();
    chk({tag, ".top"}, 32'(top), n > 0 ? 32'(q[0]) : 32'd0);
    chk({tag, ".depth"}, 32'(depth_count), 32'(n));
    chk({tag, ".top_valid"}, 32'(top_valid), 32'(n != 0));
    chk({tag, ".occupancy"}, 32'(occupancy), (32'd1 << n) - 32'd1);
    chk({tag, ".stack_oflw"}, 32'(stack_oflw), 32'(m_so));
    chk({tag, ".arith_oflw"}, 32'(arith_oflw), 32'(m_ao));
    chk({tag, ".op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] d);
    int a, b, r;
    if (op == 3'd1) begin
      q.push_front(d);
      if (q.size() > D) begin
        void'(q.pop_back());
        m_so = 1'b1;
        m_ao = 1'b0;
      end
    end else if (op == 3'd2 && q.size() > 0) begin
      void'(q.pop_front());
      m_so = 1'b0;
      m_ao = 1'b0;
    end else if ((op == 3'd3 || op == 3'd4 || (op == 3'd5 && SUB)) && q.size() >= 2) begin
      a = $signed(q.pop_front());
      b = $signed(q.pop_front());
      r = op == 3'd3 ? a + b : op == 3'd4 ? a * b : b - a;
      m_ao = r > (2 ** (W-1)) - 1 || r < -(2 ** (W-1));
      m_so = 1'b0;
      q.push_front(W'(r));
    end else if (op == 3'd6) begin
      q.delete();
      m_so = 1'b0;
      m_ao = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] d);
    int exp_busy = (op == 3'd4 && q.size() >= 2) ? W + 1 : 0;
    int n = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code = op;
    din = d;
    @(posedge clk);
    #1;
    op_code = 3'd1;
    din = 8'h55;
    while (!op_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    op_valid = 1'b0;
    model(op, d);
    chk("busy_cycles", 32'(n), 32'(exp_busy));
    check_all($sformatf("op%0d", op));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_so = 1'b0;
    m_ao = 1'b0;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] op;
    do_reset();
    issue(3'd1, 8'h05); issue(3'd1, 8'hFD);
    chk("t1_top", 32'(top), 32'hFD);
    do_reset();
    for (int i = 1; i <= 5; i++) issue(3'd1, W'(i));
    chk("t2_oflw", 32'(stack_oflw), 32'd1);
    repeat (3) issue(3'd2, '0);
    chk("t2_top", 32'(top), 32'd2);
    do_reset();
    issue(3'd1, 8'd100); issue(3'd1, 8'd50); issue(3'd3, '0);
    chk("t3_top", 32'(top), 32'h96);
    issue(3'd1, 8'd1); issue(3'd3, '0);
    chk("t3_top2", 32'(top), 32'h97);
    do_reset();
    issue(3'd1, 8'hFD); issue(3'd1, 8'd7); issue(3'd4, '0);
    chk("t4_top", 32'(top), 32'hEB);
    issue(3'd1, 8'd16); issue(3'd1, 8'd16); issue(3'd4, '0);
    chk("t4_ov", 32'(arith_oflw), 32'd1);
    do_reset();
    issue(3'd2, '0); issue(3'd1, 8'd9); issue(3'd3, '0); issue(3'd4, '0);
    chk("t5_top", 32'(top), 32'd9);
    issue(3'd1, 8'd3); issue(3'd5, '0);
    chk("t5_sub", 32'(top), SUB ? 32'd6 : 32'd3);
    issue(3'd1, 8'hC3); issue(3'd4, '0);
    @(negedge clk);
    op_valid = 1'b1;
    op_code = 3'd4;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("t6_busy", 32'(op_ready), 32'd0);
    repeat (3) @(posedge clk);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      if (op == 3'd6 && $urandom_range(0, 3) != 0) op = 3'd4;
      issue(op, W'($urandom));
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rpn_stack_unit.md
Name: rpn_stack_unit

Overview:
- Dedicated hardware RPN operand stack and ALU, parametrised in data width and stack depth.
- Executes PUSH/POP/ADD/MULT/CLEAR directly; the microcoded CPU no longer has to sequence these operations.
- Sits between the debounced button/switch front end (op requests, switch data) and the 7-segment/LED output drivers (top, top_valid, occupancy, overflow flags).
- Multiply is iterative, so the block presents a valid/ready request handshake.

Parameters:
WIDTH, 8, data width of stack entries, input, result; two's-complement signed.
DEPTH, 4, number of stack entries; must be >= 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous reset, active low.
op_valid  in  1  operation request.
op_ready  out  1  block can accept an op; an op is accepted on a cycle where op_valid && op_ready.
op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 MULT, 5 SUB (optional), 6 CLEAR, 7 NOP.
din  in  WIDTH  operand for PUSH, sampled at acceptance.
top  out  WIDTH  stack entry 0 (most recent).
top_valid  out  1  display enable; high iff depth_count != 0.
depth_count  out  $clog2(DEPTH+1)  entries held, 0..DEPTH.
occupancy  out  DEPTH  thermometer code; bit i high iff depth_count > i.
stack_oflw  out  1  stack overflow flag.
arith_oflw  out  1  arithmetic overflow flag.
busy  out  1  equals ~op_ready.

Behaviour:
- Reset (rst_n low at an edge): all entries 0, depth_count 0, occupancy 0, top 0, top_valid 0, both flags 0, FSM to IDLE, op_ready 1. A reset during MULT aborts it with no write-back.
- FSM states:
  - IDLE: op_ready=1.
  - MUL: WIDTH cycles, op_ready=0.
  - COMMIT: 1 cycle, op_ready=0.
- Single-cycle ops: accepted at edge k; results visible after edge k.
- PUSH:
  - Entries shift down: entry i+1 <- entry i; entry DEPTH-1 is discarded; entry 0 <- din.
  - If depth_count < DEPTH: depth_count +1, stack_oflw unchanged.
  - If full: depth_count stays DEPTH, stack_oflw <- 1, arith_oflw <- 0.
- POP:
  - If empty: no-op; op accepted, nothing changes.
  - Otherwise: entry i <- entry i+1; entry DEPTH-1 <- 0; depth_count -1; both flags <- 0.
- ADD / SUB:
  - If depth_count < 2: no-op; op accepted, nothing changes.
  - Otherwise: entry 0 <- (e0 + e1) or (e1 - e0), low WIDTH bits, wrap-around. Then entries 1.. shift up, entry DEPTH-1 <- 0, depth_count -1.
  - stack_oflw <- 0.
  - arith_oflw <- 1 iff signed overflow, i.e. operand signs agree (ADD) or differ (SUB) and result sign differs from e0/e1 respectively; else 0.
- MULT:
  - If depth_count < 2: no-op, single cycle.
  - Otherwise: accepted at edge k, enter MUL. Signed shift-add over WIDTH cycles into a 2*WIDTH accumulator, using absolute values plus sign correction.
  - COMMIT writes the result with the same shift-up/depth update as ADD. Result and flags are visible after edge k+WIDTH+1, the same edge op_ready returns high.
  - arith_oflw <- 1 iff the full 2*WIDTH product is not the sign extension of its low WIDTH bits.
  - Entries and top hold their pre-op values during MUL.
- CLEAR: identical to reset except it takes effect only via the handshake.
- NOP/reserved codes: accepted, no state change.
- op_valid while op_ready=0: ignored, not queued; the requester holds the request.
- Ops are mutually exclusive per cycle by construction; there are no simultaneous-event conflicts beyond reset, and reset has priority.

Optional Feature:
RPN_SUB_EN:
- Defined: op_code 5 performs SUB (e1 - e0) as specified above.
- Undefined: op_code 5 is treated as NOP, and no subtractor logic is generated.

Test Plan:
1. Reset; PUSH 0x05, PUSH 0xFD -> top=0xFD, depth_count=2, occupancy=0011, top_valid=1, flags 0.
2. PUSH 1,2,3,4,5 -> after 5th: top=5, depth_count=4, stack_oflw=1. Then POP x3 -> top=2, depth_count=1, stack_oflw=0 after the first POP (entry 1 lost).
3. PUSH 100, PUSH 50, ADD -> top=0x96, arith_oflw=1, depth_count=1. Then PUSH 1, ADD -> top=0x97, arith_oflw=0.
4. PUSH 0xFD, PUSH 7, MULT -> op_ready low exactly 9 cycles, top=0xEB, arith_oflw=0. Then PUSH 16, PUSH 16, MULT -> top=0x00, arith_oflw=1.
5. From reset: POP, then ADD with depth 1 after PUSH 9, then MULT -> no state change, op_ready never drops, top=9; with RPN_SUB_EN, PUSH 3, SUB -> top=0x06.
6. Start MULT, assert rst_n low at MUL cycle 4 -> all outputs at reset values after that edge, op_ready=1, depth_count=0.
